// File: rtl/tlul_pkg.sv
// Shared TL-UL type definitions: A/D channel opcodes and the host-to-device /
// device-to-host channel bundles used by every TL-UL block.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_cdc_adapter.sv
// Single-outstanding TL-UL adapter: registers one host request, forwards it to
// the peripheral, returns its response, and synthesizes an error on timeout.
module tlul_cdc_adapter
    import tlul_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 32
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h2d_main,
    output tl_d2h_t tl_d2h_main,
    output tl_h2d_t tl_h2d_peri,
    input  tl_d2h_t tl_d2h_peri,
    output logic    timeout_err_o
);

    localparam int CntW = $clog2(TimeoutCycles) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        RESP
    } state_e;

    state_e          state_reg, state_next;
    tl_h2d_t         req_reg, req_next;
    tl_d2h_t         rsp_reg, rsp_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic            timeout_err, timeout_next;
    logic            cnt_hit;

    // >= rather than == so a handshake that wins on the last cycle of REQ
    // still leaves RSP guarded once the budget is spent.
    assign cnt_hit = (cnt_reg >= CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            req_reg     <= '0;
            rsp_reg     <= '0;
            cnt_reg     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_reg     <= req_next;
            rsp_reg     <= rsp_next;
            cnt_reg     <= cnt_next;
            timeout_err <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        req_next     = req_reg;
        rsp_next     = rsp_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_err;

        if ((state_reg == REQ || state_reg == RSP) && (cnt_reg != {CntW{1'b1}})) begin
            cnt_next = cnt_reg + CntW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (tl_h2d_main.a_valid) begin
                    req_next         = tl_h2d_main;
                    req_next.a_valid = 1'b0;
                    req_next.d_ready = 1'b0;
                    cnt_next         = '0;
                    state_next       = REQ;
                end
            end
            REQ, RSP: begin
                if (state_reg == REQ && tl_d2h_peri.a_ready) begin
                    state_next = RSP;
                end else if (state_reg == RSP && tl_d2h_peri.d_valid) begin
                    rsp_next         = tl_d2h_peri;
                    rsp_next.d_valid = 1'b0;
                    rsp_next.a_ready = 1'b0;
                    state_next       = RESP;
                end else if (cnt_hit) begin
                    rsp_next          = '0;
                    rsp_next.d_opcode = (req_reg.a_opcode == Get) ? AccessAckData : AccessAck;
                    rsp_next.d_size   = req_reg.a_size;
                    rsp_next.d_source = req_reg.a_source;
                    rsp_next.d_data   = 32'hFFFF_FFFF;
                    rsp_next.d_error  = 1'b1;
                    timeout_next      = 1'b1;
                    state_next        = RESP;
                end
            end
            RESP: begin
                if (tl_h2d_main.d_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Idle keeps peripheral d_ready high to drain stale responses, except while
    // reset is held so the peripheral side reads as fully quiet.
    always_comb begin
        tl_d2h_main         = '0;
        tl_h2d_peri         = '0;
        tl_d2h_main.a_ready = (state_reg == IDLE);
        tl_h2d_peri.d_ready = ((state_reg == IDLE) && rst_ni) || (state_reg == RSP);
        if (state_reg == REQ) begin
            tl_h2d_peri         = req_reg;
            tl_h2d_peri.a_valid = 1'b1;
            tl_h2d_peri.d_ready = 1'b0;
        end
        if (state_reg == RESP) begin
            tl_d2h_main         = rsp_reg;
            tl_d2h_main.d_valid = 1'b1;
            tl_d2h_main.a_ready = 1'b0;
        end
    end

    assign timeout_err_o = timeout_err;

endmodule

// File: tb/tb_tlul_cdc_adapter.sv
// Directed bench for tlul_cdc_adapter: host and peripheral driven from tasks,
// expected values are hand-computed constants.
module tb_tlul_cdc_adapter;
    import tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    tl_h2d_t h2d_main, h2d_peri;
    tl_d2h_t d2h_main, d2h_peri;
    logic    timeout_err_o;
    int      checks = 0;
    int      errors = 0;

    tlul_cdc_adapter #(.TimeoutCycles(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tl_h2d_main   (h2d_main),
        .tl_d2h_main   (d2h_main),
        .tl_h2d_peri   (h2d_peri),
        .tl_d2h_peri   (d2h_peri),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    // Host issues one request; called and returns on a falling edge.
    task automatic host_send(input tl_a_op_e op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [7:0] src, output bit ok);
        int n = 0;
        h2d_main.a_valid   = 1'b1;
        h2d_main.a_opcode  = op;
        h2d_main.a_param   = 3'd0;
        h2d_main.a_size    = 2'd2;
        h2d_main.a_source  = src;
        h2d_main.a_address = addr;
        h2d_main.a_mask    = 4'hF;
        h2d_main.a_data    = data;
        h2d_main.a_user    = 16'h00A5;
        while (!d2h_main.a_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = d2h_main.a_ready;
        @(negedge clk);
        h2d_main.a_valid = 1'b0;
    endtask

    task automatic peri_accept(input int delay, output tl_h2d_t seen, output bit ok);
        int n = 0;
        while (!h2d_peri.a_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = h2d_peri.a_valid;
        repeat (delay) @(negedge clk);
        seen = h2d_peri;
        d2h_peri.a_ready = 1'b1;
        @(negedge clk);
        d2h_peri.a_ready = 1'b0;
    endtask

    task automatic peri_respond(input tl_d_op_e op, input logic [31:0] data, input logic [7:0] src,
                                output bit ok);
        int n = 0;
        while (!h2d_peri.d_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = h2d_peri.d_ready;
        d2h_peri.d_valid  = 1'b1;
        d2h_peri.d_opcode = op;
        d2h_peri.d_param  = 3'd0;
        d2h_peri.d_size   = 2'd2;
        d2h_peri.d_source = src;
        d2h_peri.d_sink   = 1'b1;
        d2h_peri.d_data   = data;
        d2h_peri.d_user   = 16'h5A5A;
        d2h_peri.d_error  = 1'b0;
        @(negedge clk);
        d2h_peri.d_valid = 1'b0;
    endtask

    // Returns the response seen first and again just before d_ready is raised.
    task automatic host_recv(input int hold, output tl_d2h_t got, output tl_d2h_t got_late,
                             output bit ok);
        int n = 0;
        while (!d2h_main.d_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok  = d2h_main.d_valid;
        got = d2h_main;
        repeat (hold) @(negedge clk);
        got_late = d2h_main;
        h2d_main.d_ready = 1'b1;
        @(negedge clk);
        h2d_main.d_ready = 1'b0;
    endtask

    task automatic test_reset();
        tl_d2h_t exp_d;
        tl_h2d_t zero_h;
        exp_d = '0;
        exp_d.a_ready = 1'b1;
        zero_h = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (d2h_main !== exp_d) begin
            errors++;
            $display("FAIL reset_main: got %h expected %h", d2h_main, exp_d);
        end
        checks++;
        if (h2d_peri !== zero_h) begin
            errors++;
            $display("FAIL reset_peri: got %h expected %h", h2d_peri, zero_h);
        end
        checks++;
        if (timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout_err: got %b expected 0", timeout_err_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (d2h_main.a_ready !== 1'b1 || h2d_peri.d_ready !== 1'b1 || h2d_peri.a_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got a_ready=%b d_ready=%b a_valid=%b expected 1 1 0",
                     d2h_main.a_ready, h2d_peri.d_ready, h2d_peri.a_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_put();
        bit ok1, ok2, ok3, ok4, lat;
        tl_h2d_t seen;
        tl_d2h_t got, got_late;
        host_send(PutFullData, 32'h4000_0000, 32'hDEAD_BEEF, 8'h11, ok1);
        lat = h2d_peri.a_valid;
        peri_accept(2, seen, ok2);
        peri_respond(AccessAck, 32'h0, 8'h11, ok3);
        host_recv(0, got, got_late, ok4);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            errors++;
            $display("FAIL put_handshakes: got %b%b%b%b expected 1111", ok1, ok2, ok3, ok4);
        end
        checks++;
        if (lat !== 1'b1) begin
            errors++;
            $display("FAIL put_latency: peri a_valid one cycle after accept got %b expected 1", lat);
        end
        checks++;
        if (seen.a_opcode !== PutFullData || seen.a_address !== 32'h4000_0000 ||
            seen.a_data !== 32'hDEAD_BEEF || seen.a_source !== 8'h11 ||
            seen.a_mask !== 4'hF || seen.a_user !== 16'h00A5 || seen.a_size !== 2'd2) begin
            errors++;
            $display("FAIL put_forward: got op=%0d addr=%h data=%h src=%h expected 0 40000000 deadbeef 11",
                     seen.a_opcode, seen.a_address, seen.a_data, seen.a_source);
        end
        checks++;
        if (got.d_opcode !== AccessAck || got.d_error !== 1'b0 || got.d_source !== 8'h11 ||
            got.d_sink !== 1'b1 || got.d_user !== 16'h5A5A || timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL put_response: got op=%0d err=%b src=%h terr=%b expected 0 0 11 0",
                     got.d_opcode, got.d_error, got.d_source, timeout_err_o);
        end
        $display("put: addr=%h data=%h rsp_op=%0d err=%b", seen.a_address, seen.a_data,
                 got.d_opcode, got.d_error);
    endtask

    task automatic test_get();
        bit ok1, ok2, ok3, ok4;
        tl_h2d_t seen;
        tl_d2h_t got, got_late;
        host_send(Get, 32'h4000_0000, 32'h0, 8'h22, ok1);
        peri_accept(1, seen, ok2);
        peri_respond(AccessAckData, 32'hDEAD_BEEF, 8'h22, ok3);
        host_recv(2, got, got_late, ok4);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            errors++;
            $display("FAIL get_handshakes: got %b%b%b%b expected 1111", ok1, ok2, ok3, ok4);
        end
        checks++;
        if (got.d_data !== 32'hDEAD_BEEF || got.d_opcode !== AccessAckData ||
            got.d_error !== 1'b0 || got.d_source !== 8'h22) begin
            errors++;
            $display("FAIL get_response: got data=%h op=%0d err=%b expected deadbeef 1 0",
                     got.d_data, got.d_opcode, got.d_error);
        end
        checks++;
        if (got_late !== got) begin
            errors++;
            $display("FAIL get_hold: got %h expected %h", got_late, got);
        end
        $display("get: addr=%h data=%h rsp_op=%0d", seen.a_address, got.d_data, got.d_opcode);
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3, ok4, ok5, ok6, ok7, blocked, released;
        tl_h2d_t seen1, seen2;
        tl_d2h_t got, got_late;
        host_send(PutFullData, 32'h4000_1000, 32'h1234_5678, 8'h01, ok1);
        repeat (4) @(negedge clk);
        h2d_main.a_valid   = 1'b1;
        h2d_main.a_address = 32'h4000_1004;
        h2d_main.a_data    = 32'h8765_4321;
        h2d_main.a_source  = 8'h02;
        blocked = (d2h_main.a_ready === 1'b0);
        peri_accept(0, seen1, ok2);
        peri_respond(AccessAck, 32'h0, 8'h01, ok3);
        host_recv(0, got, got_late, ok4);
        blocked = blocked && (got.a_ready === 1'b0);
        released = (d2h_main.a_ready === 1'b1);
        @(negedge clk);
        h2d_main.a_valid = 1'b0;
        peri_accept(0, seen2, ok5);
        peri_respond(AccessAck, 32'h0, 8'h02, ok6);
        host_recv(0, got, got_late, ok7);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4 && ok5 && ok6 && ok7)) begin
            errors++;
            $display("FAIL b2b_handshakes: got %b%b%b%b%b%b%b expected all 1",
                     ok1, ok2, ok3, ok4, ok5, ok6, ok7);
        end
        checks++;
        if (!blocked || !released) begin
            errors++;
            $display("FAIL b2b_backpressure: got blocked=%b released=%b expected 1 1", blocked, released);
        end
        checks++;
        if (seen1.a_address !== 32'h4000_1000 || seen1.a_data !== 32'h1234_5678 ||
            seen2.a_address !== 32'h4000_1004 || seen2.a_data !== 32'h8765_4321) begin
            errors++;
            $display("FAIL b2b_order: got %h/%h then %h/%h expected 40001000/12345678 then 40001004/87654321",
                     seen1.a_address, seen1.a_data, seen2.a_address, seen2.a_data);
        end
        checks++;
        if (got.d_source !== 8'h02) begin
            errors++;
            $display("FAIL b2b_second_rsp: got src=%h expected 02", got.d_source);
        end
        $display("b2b: first %h/%h second %h/%h", seen1.a_address, seen1.a_data,
                 seen2.a_address, seen2.a_data);
    endtask

    task automatic test_ignore_in_rsp();
        bit ok1, ok2, ok3, ok4, no_ready;
        int extra = 0;
        tl_h2d_t seen;
        tl_d2h_t got, got_late;
        host_send(Get, 32'h4000_2000, 32'h0, 8'h33, ok1);
        peri_accept(0, seen, ok2);
        h2d_main.a_valid   = 1'b1;
        h2d_main.a_address = 32'h4000_3000;
        h2d_main.a_source  = 8'h77;
        no_ready = (d2h_main.a_ready === 1'b0);
        @(negedge clk);
        no_ready = no_ready && (d2h_main.a_ready === 1'b0);
        @(negedge clk);
        h2d_main.a_valid = 1'b0;
        peri_respond(AccessAckData, 32'hCAFE_F00D, 8'h33, ok3);
        host_recv(0, got, got_late, ok4);
        repeat (5) begin
            if (h2d_peri.a_valid === 1'b1) extra++;
            @(negedge clk);
        end
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4) || !no_ready) begin
            errors++;
            $display("FAIL ignore_handshakes: got ok=%b%b%b%b no_ready=%b expected 1111 1",
                     ok1, ok2, ok3, ok4, no_ready);
        end
        checks++;
        if (extra != 0 || got.d_source !== 8'h33 || got.d_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL ignore_no_capture: got extra=%0d src=%h data=%h expected 0 33 cafef00d",
                     extra, got.d_source, got.d_data);
        end
        $display("ignore_in_rsp: extra_requests=%0d src=%h", extra, got.d_source);
    endtask

    task automatic test_coincide();
        bit ok1, ok2, ok3, ok4;
        tl_h2d_t seen;
        tl_d2h_t got, got_late;
        host_send(Get, 32'h4000_4000, 32'h0, 8'h44, ok1);
        peri_accept(31, seen, ok2);
        peri_respond(AccessAckData, 32'h0BAD_CAFE, 8'h44, ok3);
        host_recv(0, got, got_late, ok4);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4) || got.d_error !== 1'b0 ||
            got.d_data !== 32'h0BAD_CAFE || timeout_err_o !== 1'b0) begin
            errors++;
            $display("FAIL coincide: got ok=%b%b%b%b err=%b data=%h terr=%b expected 1111 0 0badcafe 0",
                     ok1, ok2, ok3, ok4, got.d_error, got.d_data, timeout_err_o);
        end
        $display("coincide: err=%b data=%h", got.d_error, got.d_data);
    endtask

    task automatic test_timeout_get();
        bit ok1, ok2, valid_first, sticky;
        int n = 0;
        tl_d2h_t got, got_late;
        host_send(Get, 32'h5000_0000, 32'h0, 8'h55, ok1);
        valid_first = h2d_peri.a_valid;
        while (!d2h_main.d_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 32 || !ok1 || valid_first !== 1'b1) begin
            errors++;
            $display("FAIL timeout_latency: got cycles=%0d ok=%b a_valid=%b expected 32 1 1",
                     n, ok1, valid_first);
        end
        checks++;
        if (h2d_peri.a_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop_valid: got %b expected 0", h2d_peri.a_valid);
        end
        checks++;
        if (timeout_err_o !== 1'b1 || dut.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got out=%b int=%b expected 1 1", timeout_err_o, dut.timeout_err);
        end
        host_recv(0, got, got_late, ok2);
        checks++;
        if (!ok2 || got.d_opcode !== AccessAckData || got.d_error !== 1'b1 ||
            got.d_data !== 32'hFFFF_FFFF || got.d_source !== 8'h55 || got.d_size !== 2'd2 ||
            got.d_param !== 3'd0 || got.d_sink !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: got op=%0d err=%b data=%h src=%h size=%0d expected 1 1 ffffffff 55 2",
                     got.d_opcode, got.d_error, got.d_data, got.d_source, got.d_size);
        end
        sticky = 1'b1;
        repeat (5) begin
            @(negedge clk);
            sticky = sticky && (timeout_err_o === 1'b1);
        end
        checks++;
        if (!sticky) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout_err_o);
        end
        $display("timeout_get: cycles=%0d op=%0d err=%b data=%h", n, got.d_opcode, got.d_error, got.d_data);
    endtask

    task automatic test_timeout_rsp();
        bit ok1, ok2, ok3;
        tl_h2d_t seen;
        tl_d2h_t got, got_late;
        host_send(PutFullData, 32'h5000_0004, 32'h1111_2222, 8'h5A, ok1);
        peri_accept(3, seen, ok2);
        host_recv(0, got, got_late, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || got.d_opcode !== AccessAck || got.d_error !== 1'b1 ||
            got.d_data !== 32'hFFFF_FFFF || got.d_source !== 8'h5A) begin
            errors++;
            $display("FAIL timeout_in_rsp: got ok=%b%b%b op=%0d err=%b src=%h expected 111 0 1 5a",
                     ok1, ok2, ok3, got.d_opcode, got.d_error, got.d_source);
        end
        $display("timeout_rsp: op=%0d err=%b", got.d_opcode, got.d_error);
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, quiet;
        tl_h2d_t seen, zero_h;
        zero_h = '0;
        host_send(PutFullData, 32'h4000_5000, 32'hAAAA_5555, 8'h66, ok1);
        peri_accept(0, seen, ok2);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (!(ok1 && ok2) || d2h_main.d_valid !== 1'b0 || d2h_main.a_ready !== 1'b1 ||
            h2d_peri !== zero_h || dut.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ok=%b%b d_valid=%b a_ready=%b peri=%h terr=%b expected 11 0 1 0 0",
                     ok1, ok2, d2h_main.d_valid, d2h_main.a_ready, h2d_peri, dut.timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            quiet = quiet && (d2h_main.d_valid === 1'b0) && (d2h_main.a_ready === 1'b1);
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_mid_after: got d_valid=%b a_ready=%b expected 0 1",
                     d2h_main.d_valid, d2h_main.a_ready);
        end
        $display("reset_mid: a_ready=%b d_valid=%b", d2h_main.a_ready, d2h_main.d_valid);
    endtask

    initial begin
        h2d_main = '0;
        d2h_peri = '0;
        rst_n    = 1'b0;
        @(negedge clk);
        test_reset();
        test_put();
        test_get();
        test_back_to_back();
        test_ignore_in_rsp();
        test_coincide();
        test_timeout_get();
        test_timeout_rsp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
